// File: rtl/rect_fill.sv
// Rectangle fill engine: latches a rectangle and colour, clips it to the visible
// area and streams one pixel write per accepted cycle into the pixel RAM.
module rect_fill #(
  parameter int H_PIX = 640,
  parameter int V_PIX = 480
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [11:0] color,
  input  logic        wr_ready,
  output logic        wrn,
  output logic [8:0]  wr_row,
  output logic [9:0]  wr_col,
  output logic [11:0] wr_data,
  output logic        busy,
  output logic        done
);

  localparam logic [9:0] X_LIM = 10'(H_PIX - 1);
  localparam logic [8:0] Y_LIM = 9'(V_PIX - 1);

  typedef enum logic [1:0] {IDLE, CLIP, FILL} state_t;

  state_t     state;
  logic [9:0] lat_x0, lat_x1;
  logic [8:0] lat_y0, lat_y1;
  logic [9:0] xmin_q, xmax_q;
  logic [8:0] ymax_q;

  logic [9:0] xmin, xmax;
  logic [8:0] ymin, ymax;
  logic       off_screen;
  logic       last_pix;
  logic       accept;

  // Normalise the latched corners and clamp the far edges to the screen.
  always_comb begin
    xmin = (lat_x0 < lat_x1) ? lat_x0 : lat_x1;
    xmax = (lat_x0 < lat_x1) ? lat_x1 : lat_x0;
    ymin = (lat_y0 < lat_y1) ? lat_y0 : lat_y1;
    ymax = (lat_y0 < lat_y1) ? lat_y1 : lat_y0;
    if (xmax > X_LIM) xmax = X_LIM;
    if (ymax > Y_LIM) ymax = Y_LIM;
    off_screen = (xmin > X_LIM) || (ymin > Y_LIM);
  end

  assign accept   = !wrn && wr_ready;
  assign last_pix = (wr_col == xmax_q) && (wr_row == ymax_q);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      wrn     <= 1'b1;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lat_x0  <= '0;
      lat_x1  <= '0;
      lat_y0  <= '0;
      lat_y1  <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lat_x0  <= x0;
            lat_x1  <= x1;
            lat_y0  <= y0;
            lat_y1  <= y1;
            wr_data <= color;
            busy    <= 1'b1;
            state   <= CLIP;
          end
        end
        CLIP: begin
          xmin_q <= xmin;
          xmax_q <= xmax;
          ymax_q <= ymax;
          if (off_screen) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wr_row <= ymin;
            wr_col <= xmin;
            wrn    <= 1'b0;
            state  <= FILL;
          end
        end
        FILL: begin
          // The cursor only moves on an accepted write, so a stall holds everything.
          if (accept) begin
            if (last_pix) begin
              wrn   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (wr_col < xmax_q) begin
              wr_col <= wr_col + 10'd1;
            end else begin
              wr_col <= xmin_q;
              wr_row <= wr_row + 9'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill.sv
// Scoreboard bench for rect_fill: expected pixels are queued when a command is
// issued and compared against every write the engine presents.
module tb_rect_fill;

  logic        vga_clk = 1'b0;
  logic        clrn;
  logic        start;
  logic [9:0]  x0, x1;
  logic [8:0]  y0, y1;
  logic [11:0] color;
  logic        wr_ready = 1'b1;
  logic        wrn;
  logic [8:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  logic [30:0] exp_q[$];
  int acc_cnt   = 0;
  int done_seen = 0;
  logic bp_mode = 1'b0;
  int bp_cnt    = 0;

  logic [33:0] out_vec;
  localparam logic [33:0] RESET_VEC = {1'b1, 33'd0};
  assign out_vec = {wrn, busy, done, wr_row, wr_col, wr_data};

  rect_fill dut (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .start   (start),
    .x0      (x0),
    .x1      (x1),
    .y0      (y0),
    .y1      (y1),
    .color   (color),
    .wr_ready(wr_ready),
    .wrn     (wrn),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done)
  );

  always #20 vga_clk = ~vga_clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Ready pattern 1,0,0 repeating when backpressure is enabled.
  always @(posedge vga_clk) begin
    #1;
    if (bp_mode) begin
      wr_ready = (bp_cnt % 3 == 0);
      bp_cnt++;
    end else begin
      wr_ready = 1'b1;
    end
  end

  // Every presented write must match the head of the scoreboard, stalled or not.
  always @(negedge vga_clk) begin
    if (done) done_seen++;
    if (clrn && !wrn) begin
      if (exp_q.size() == 0) begin
        checkOutput("write_while_empty", 64'(wrn), 64'd1);
      end else begin
        checkOutput("pixel", 64'({wr_row, wr_col, wr_data}), 64'(exp_q[0]));
        if (wr_ready) begin
          void'(exp_q.pop_front());
          acc_cnt++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [9:0] ax0, input logic [9:0] ax1,
                               input logic [8:0] ay0, input logic [8:0] ay1,
                               input logic [11:0] acolor, input bit check_lat,
                               input int restart_at);
    int xl, xh, yl, yh, n, lat, cyc;
    bit got;
    xl = (ax0 < ax1) ? int'(ax0) : int'(ax1);
    xh = (ax0 < ax1) ? int'(ax1) : int'(ax0);
    yl = (ay0 < ay1) ? int'(ay0) : int'(ay1);
    yh = (ay0 < ay1) ? int'(ay1) : int'(ay0);
    if (xh > 639) xh = 639;
    if (yh > 479) yh = 479;
    n = 0;
    if (xl <= 639 && yl <= 479) begin
      for (int r = yl; r <= yh; r++) begin
        for (int c = xl; c <= xh; c++) begin
          exp_q.push_back({9'(r), 10'(c), acolor});
          n++;
        end
      end
    end
    lat = n + 2;

    x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; color = acolor;
    start = 1'b1;
    @(posedge vga_clk); #1;
    start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge vga_clk);
      cyc++;
      if (cyc == 1) checkOutput("busy_after_start", 64'(busy), 64'd1);
      if (done) begin
        got = 1'b1;
      end else begin
        @(posedge vga_clk); #1;
        if (cyc == restart_at) begin
          x0 = 10'd5; x1 = 10'd6; y0 = 9'd5; y1 = 9'd6; color = 12'h111;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (!got) checkOutput("done_timeout", 64'(done), 64'd1);
    else if (check_lat) checkOutput("latency", 64'(cyc), 64'(lat));
    @(posedge vga_clk); #1;
    @(negedge vga_clk);
    checkOutput("post_idle", 64'({busy, wrn, done}), 64'(3'b010));
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge vga_clk); #1;
  endtask

  task automatic applyAbort();
    int base, done_before, cyc;
    for (int r = 5; r <= 6; r++)
      for (int c = 10; c <= 12; c++)
        exp_q.push_back({9'(r), 10'(c), 12'h123});
    base = acc_cnt;
    x0 = 10'd10; x1 = 10'd12; y0 = 9'd5; y1 = 9'd6; color = 12'h123;
    start = 1'b1;
    @(posedge vga_clk); #1;
    start = 1'b0;
    cyc = 0;
    while (acc_cnt - base < 3 && cyc < 100) begin
      @(negedge vga_clk);
      cyc++;
    end
    checkOutput("abort_three_writes", 64'(acc_cnt - base), 64'd3);
    @(posedge vga_clk); #1;
    done_before = done_seen;
    clrn = 1'b0;
    #1;
    checkOutput("abort_immediate", 64'(out_vec), 64'(RESET_VEC));
    exp_q.delete();
    repeat (2) begin
      @(negedge vga_clk);
      checkOutput("abort_hold", 64'(out_vec), 64'(RESET_VEC));
    end
    @(posedge vga_clk); #1;
    clrn = 1'b1;
    repeat (3) begin
      @(negedge vga_clk);
      checkOutput("abort_idle", 64'(out_vec), 64'(RESET_VEC));
    end
    checkOutput("abort_no_done", 64'(done_seen), 64'(done_before));
    @(posedge vga_clk); #1;
    applyStimulus(10'd7, 10'd7, 9'd3, 9'd3, 12'h0C3, 1'b1, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clrn = 1'b0; start = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    repeat (3) begin
      @(negedge vga_clk);
      checkOutput("reset_hold", 64'(out_vec), 64'(RESET_VEC));
    end
    @(posedge vga_clk); #1;
    clrn = 1'b1;
    repeat (10) begin
      @(negedge vga_clk);
      checkOutput("idle", 64'(out_vec), 64'(RESET_VEC));
    end
    @(posedge vga_clk); #1;

    $display("[TB] basic fill");
    applyStimulus(10'd10, 10'd12, 9'd5, 9'd6, 12'hF0A, 1'b1, 0);
    $display("[TB] swapped corners and clipping");
    applyStimulus(10'd1000, 10'd638, 9'd479, 9'd479, 12'h3C5, 1'b1, 0);
    $display("[TB] off-screen");
    applyStimulus(10'd700, 10'd700, 9'd0, 9'd3, 12'h777, 1'b1, 0);
    $display("[TB] single pixel");
    applyStimulus(10'd0, 10'd0, 9'd0, 9'd0, 12'h5A5, 1'b1, 0);
    $display("[TB] backpressure with ignored start");
    bp_mode = 1'b1;
    applyStimulus(10'd21, 10'd20, 9'd31, 9'd30, 12'hABC, 1'b0, 3);
    bp_mode = 1'b0;
    @(posedge vga_clk); #1;
    $display("[TB] abort and restart");
    applyAbort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_fill.md
# rect_fill

Rectangle fill engine: the write-side client of the 640x480 pixel RAM that the VGA controller scans out. On a start pulse it latches a rectangle and a 12-bit colour, normalises and clips the rectangle to the visible area, then streams one pixel write per cycle into the pixel RAM write port in raster order. It shares `vga_clk` with the controller through the dual-port pixel RAM. Its address format (9-bit row, 10-bit column) and pixel format (bbbb_gggg_rrrr) match the read side exactly.

## Interface
Parameters:
- `H_PIX`, 640, visible columns; clip limit is `H_PIX-1`.
- `V_PIX`, 480, visible rows; clip limit is `V_PIX-1`.

Ports:
- `vga_clk`  in  1  clock, 25 MHz; all logic is on the rising edge.
- `clrn`  in  1  reset, asynchronous and active-low.
- `start`  in  1  command strobe; sampled only in IDLE.
- `x0`, `x1`  in  10  column corners, any order, may exceed 639.
- `y0`, `y1`  in  9  row corners, any order, may exceed 479.
- `color`  in  12  fill pixel, bbbb_gggg_rrrr.
- `wr_ready`  in  1  RAM port accepts a write this cycle.
- `wrn`  out  1  pixel write request, active-low.
- `wr_row`  out  9  pixel RAM row address.
- `wr_col`  out  10  pixel RAM column address.
- `wr_data`  out  12  pixel written.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CLIP, FILL.
- **IDLE:** when `start`=1, latch `x0`/`x1`/`y0`/`y1`/`color`, set `busy`=1, go to CLIP. The latched colour is used for the whole command.
- **CLIP:** one cycle.
  - Normalise: xmin=min(x0,x1), xmax=max(x0,x1); same for y.
  - Clamp xmax to 639 and ymax to 479.
  - If xmin>639 or ymin>479, the rectangle is fully off-screen: issue no writes, pulse `done`, clear `busy`, return to IDLE.
  - Otherwise load the cursor (row=ymin, col=xmin), drive `wrn`=0, and go to FILL.
- **FILL:**
  - A write is accepted on any edge where `wrn`=0 and `wr_ready`=1.
  - On acceptance: if col<xmax, col+1; else col=xmin and row+1.
  - After the pixel at (ymax,xmax) is accepted: `wrn`=1, `done`=1 for one cycle, `busy`=0, go to IDLE.
  - When `wr_ready`=0, hold `wrn`, `wr_row`, `wr_col` and `wr_data` stable; no advance.
- **Width rules:**
  - Comparisons are unsigned at full port width.
  - Cursor increments never wrap: col ≤ 639 and row ≤ 479 always.
  - Pixel count N = (xmax-xmin+1)*(ymax-ymin+1); N=1 is legal (single pixel).
- **Start outside IDLE:** `start` in CLIP or FILL is ignored. No queueing, and no change to the latched command.
- **Outputs are registered.** Reset values: `wrn`=1, `wr_row`=0, `wr_col`=0, `wr_data`=0, `busy`=0, `done`=0, state IDLE.
- **Reset mid-operation:** `clrn` low aborts immediately to the reset values. The partially filled rectangle stays in RAM, and no `done` is issued.

## Timing
- Let edge T be the edge that samples `start`=1 in IDLE.
- After edge T: `busy`=1.
- After edge T+1: `wrn`=0, with the first pixel at (ymin,xmin).
- With `wr_ready` held high, pixel k is accepted at edge T+1+k, for k=1..N.
- After edge T+1+N: `done`=1, `busy`=0, `wrn`=1.
- Total latency with no stalls: N+2 cycles from `start` to `done`. Each stall cycle adds one cycle.
- Off-screen command: `done`=1 and `busy`=0 after edge T+1, with no cycle of `wrn`=0.
- Back-to-back commands: `start` sampled during the `done` cycle (state is IDLE) is accepted.

## Test plan
- **Reset and idle:**
  - Stimulus: hold `clrn` low, then release with `start`=0 for 10 cycles.
  - Required: `wrn`=1, `busy`=0, `done`=0 and all addresses 0 throughout.
- **Basic fill:**
  - Stimulus: x0=10, x1=12, y0=5, y1=6, color=12'hF0A, `wr_ready`=1.
  - Required: 6 writes in order (5,10),(5,11),(5,12),(6,10),(6,11),(6,12), all with data F0A.
  - Required: `done` 8 cycles after `start`.
- **Swapped corners and clipping:**
  - Stimulus: x0=1000, x1=638, y0=479, y1=479.
  - Required: writes only to (479,638) and (479,639), then `done`.
- **Off-screen and single pixel:**
  - Stimulus: x0=x1=700, y0=0, y1=3.
  - Required: no writes; `done` 2 cycles after `start`.
  - Stimulus: x0=x1=0, y0=y1=0.
  - Required: exactly one write to (0,0).
- **Backpressure and ignored start:**
  - Stimulus: 2x2 fill with `wr_ready` toggling 1,0,0,1,...; assert `start` again mid-FILL.
  - Required: outputs stable while `wr_ready`=0; exactly 4 accepted writes; the second `start` has no effect.
- **Abort and restart:**
  - Stimulus: assert `clrn` low after 3 of 6 writes, then issue a new 1x1 command.
  - Required: immediate return to reset values with no `done`; the new command completes normally.
